// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types and widths for the two-master peripheral bus arbiter.
package periph_bus_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } bus_state_t;

   localparam int BUS_DATA_W = 32;
   localparam int BUS_ADDR_W = 32;
   localparam int TMO_CNT_W  = 16;

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// One peripheral-bus port: strobes, address and data out; read data, completion and error back.
interface periph_bus_if;
   import periph_bus_pkg::*;

   logic                  read;
   logic                  write;
   logic [BUS_ADDR_W-1:0] address;
   logic [BUS_DATA_W-1:0] write_data;
   logic [BUS_DATA_W-1:0] read_data;
   logic                  response;
   logic                  error;

   modport master (
      output read, write, address, write_data,
      input  read_data, response, error
   );

   modport slave (
      input  read, write, address, write_data,
      output read_data, response, error
   );

   // Downstream side toward a peripheral that has no error line
   modport initiator (
      output read, write, address, write_data,
      input  read_data, response
   );

endinterface

// File: rtl/periph_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, contention is settled by prio.
module rr_pick2 (
   input  logic [1:0] i_req,
   input  logic       i_prio,
   output logic       o_valid,
   output logic       o_sel
);

   // Winner selection
   always_comb begin
      o_valid = 1'b0;
      o_sel   = 1'b0;
      case (i_req)
         2'b01: begin
            o_valid = 1'b1;
            o_sel   = 1'b0;
         end
         2'b10: begin
            o_valid = 1'b1;
            o_sel   = 1'b1;
         end
         2'b11: begin
            o_valid = 1'b1;
            o_sel   = i_prio;
         end
         default: begin
            o_valid = 1'b0;
            o_sel   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral bus between the core port (m0) and debug port (m1),
// with pass-through of the granted master and error completion of hung transfers.
module periph_bus_arbiter
   import periph_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   periph_bus_if.slave     m0_bus,
   periph_bus_if.slave     m1_bus,
   periph_bus_if.initiator periph_bus
);

   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 32'd1);

   bus_state_t            r_state;
   bus_state_t            w_state_nxt;
   logic                  r_grant;
   logic                  w_grant_nxt;
   logic                  r_prio;
   logic                  w_prio_nxt;
   logic [TMO_CNT_W-1:0]  r_tmo_cnt;
   logic [TMO_CNT_W-1:0]  w_tmo_cnt_nxt;

   logic [1:0]            w_req;
   logic                  w_pick_valid;
   logic                  w_pick_sel;
   logic                  w_g_read;
   logic                  w_g_write;
   logic [BUS_ADDR_W-1:0] w_g_addr;
   logic [BUS_DATA_W-1:0] w_g_wdata;
   logic                  w_tmo_hit;
   logic                  w_done_ok;
   logic                  w_done_err;
   logic                  w_resp;
   logic [BUS_DATA_W-1:0] w_resp_data;

   assign w_req     = {m1_bus.read | m1_bus.write, m0_bus.read | m0_bus.write};
   assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

   rr_pick2 u_pick (
      .i_req   (w_req),
      .i_prio  (r_prio),
      .o_valid (w_pick_valid),
      .o_sel   (w_pick_sel)
   );

   // Request of the currently granted master
   always_comb begin
      w_g_read  = 1'b0;
      w_g_write = 1'b0;
      w_g_addr  = {BUS_ADDR_W{1'b0}};
      w_g_wdata = {BUS_DATA_W{1'b0}};
      if (r_grant) begin
         w_g_read  = m1_bus.read;
         w_g_write = m1_bus.write;
         w_g_addr  = m1_bus.address;
         w_g_wdata = m1_bus.write_data;
      end else begin
         w_g_read  = m0_bus.read;
         w_g_write = m0_bus.write;
         w_g_addr  = m0_bus.address;
         w_g_wdata = m0_bus.write_data;
      end
   end

   // Peripheral side; kept apart from next-state logic so a combinational response cannot loop back
   always_comb begin
      periph_bus.read       = 1'b0;
      periph_bus.write      = 1'b0;
      periph_bus.address    = {BUS_ADDR_W{1'b0}};
      periph_bus.write_data = {BUS_DATA_W{1'b0}};
      if (r_state == BUSY) begin
         periph_bus.read       = w_g_read & ~w_tmo_hit;
         periph_bus.write      = w_g_write & ~w_tmo_hit;
         periph_bus.address    = w_g_addr;
         periph_bus.write_data = w_g_wdata;
      end else begin
         periph_bus.read       = 1'b0;
         periph_bus.write      = 1'b0;
      end
   end

   // Next-state, grant, priority and timeout counter
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_prio_nxt    = r_prio;
      w_tmo_cnt_nxt = r_tmo_cnt;
      w_done_ok     = 1'b0;
      w_done_err    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_state_nxt   = BUSY;
               w_grant_nxt   = w_pick_sel;
               w_tmo_cnt_nxt = {TMO_CNT_W{1'b0}};
            end else begin
               w_state_nxt   = IDLE;
            end
         end
         BUSY: begin
            if (!(w_g_read | w_g_write)) begin
               // Master abandoned the access: release the bus silently, keep prio
               w_state_nxt = IDLE;
            end else if (periph_bus.response) begin
               w_done_ok   = 1'b1;
               w_state_nxt = IDLE;
               w_prio_nxt  = ~r_grant;
            end else if (w_tmo_hit) begin
               w_done_err  = 1'b1;
               w_state_nxt = IDLE;
               w_prio_nxt  = ~r_grant;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + {{(TMO_CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_resp      = w_done_ok | w_done_err;
   assign w_resp_data = w_done_ok ? periph_bus.read_data : {BUS_DATA_W{1'b0}};

   // Completion routed to the granted master only
   always_comb begin
      m0_bus.response  = w_resp & ~r_grant;
      m0_bus.error     = w_done_err & ~r_grant;
      m0_bus.read_data = r_grant ? {BUS_DATA_W{1'b0}} : w_resp_data;
      m1_bus.response  = w_resp & r_grant;
      m1_bus.error     = w_done_err & r_grant;
      m1_bus.read_data = r_grant ? w_resp_data : {BUS_DATA_W{1'b0}};
   end

   // State registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_grant   <= 1'b0;
         r_prio    <= 1'b0;
         r_tmo_cnt <= {TMO_CNT_W{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_prio    <= w_prio_nxt;
         r_tmo_cnt <= w_tmo_cnt_nxt;
      end
   end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master round-robin arbiter sharing the single peripheral bus (LED register, other memory-mapped peripherals) between the core data port (master 0) and the debug/loader port (master 1). Grants one master at a time, passes its strobes, address and data through to the peripheral, routes `read_data`/`response` back, and completes hung transfers with an error after a timeout. Sits between the masters and the peripheral address decoder.

## Interface
- `TIMEOUT_CYCLES`, 255: BUSY cycles without `response` before the access is aborted with error; range 1–65535.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `m0_read`, `m0_write` in 1 each: master 0 strobes, held until `m0_response`.
- `m0_address`, `m0_write_data` in 32 each: master 0 address/data, stable while strobe held.
- `m0_read_data` out 32: peripheral data while master 0 is granted, else 0.
- `m0_response` out 1: one-cycle completion pulse.
- `m0_error` out 1: qualifies `m0_response`; high on timeout.
- `m1_*`: identical set for master 1.
- `read`, `write` out 1 each: peripheral strobes.
- `address`, `write_data` out 32 each: peripheral address/data.
- `read_data` in 32: peripheral read data.
- `response` in 1: peripheral completion; may be combinational from `read|write`.

## Operation
- States: IDLE, BUSY (registered `grant` bit, `prio` bit, 16-bit `tmo_cnt`).
- IDLE: peripheral `read`/`write`/`address`/`write_data` all 0. If any master strobes, grant it. Both strobing → `grant <= prio`. Go to BUSY; `tmo_cnt <= 0`.
- BUSY: peripheral outputs are the combinational pass-through of the granted master. The other master sees `read_data` = 0 and `response` = 0, and waits.
- Granted master with `read` and `write` both high: forwarded unchanged; the peripheral resolves it (write takes effect).
- BUSY and `response` = 1: granted master gets `mX_response` = 1, `mX_error` = 0, and `mX_read_data` = `read_data` in the same cycle. Next state is IDLE and `prio <= ~grant`.
- BUSY, no `response`, `tmo_cnt` = `TIMEOUT_CYCLES-1`: strobes are forced to 0 that cycle. Granted master gets `mX_response` = 1, `mX_error` = 1, `mX_read_data` = 0. Next state is IDLE and `prio <= ~grant`.
- BUSY, no `response`, otherwise: `tmo_cnt` increments.
- Granted master drops both strobes in BUSY without `response` (protocol violation): strobes follow to 0 at once. Next state is IDLE. No response pulse; `prio` unchanged.
- `response` arriving in IDLE is ignored.

## Timing
- Reset: state IDLE, `grant` 0, `prio` 0 (master 0 first), `tmo_cnt` 0.
- Reset values of outputs: every output 0.
- Reset asserted mid-BUSY: peripheral strobes drop asynchronously. No response is issued. The master must reissue after reset.
- Latency: strobe first seen in IDLE at cycle N → peripheral strobe at N+1. With a zero-wait peripheral, `mX_response` also comes at N+1.
- Throughput: one IDLE cycle between transfers, so a 2-cycle minimum per access.
- The master must drop or change its strobe in the cycle after `mX_response`. A strobe still held then is treated as a new request.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1. Worst-case wait is one transfer plus one IDLE cycle.
- Timeout response comes exactly `TIMEOUT_CYCLES` BUSY cycles after grant.

## Structure
- Package `periph_bus_pkg`:
  - `bus_state_t` enum {IDLE, BUSY};
  - `BUS_DATA_W` = 32, `BUS_ADDR_W` = 32;
  - `TMO_CNT_W` = 16.
- Sub-module `rr_pick2`: combinational; inputs `req[1:0]` and `prio`; outputs `valid` and `sel`. Reusable for wider arbiters.
- All other logic (FSM, counter, muxes) lives in `periph_bus_arbiter`.

## Test plan
- **Single read:** master 0 reads 0x0000_0000 from a zero-wait model returning 0xA5 → `read` high at N+1, `m0_response`=1 with `m0_read_data`=0xA5 at N+1, `m0_error`=0; `m1_read_data`=0.
- **Simultaneous requests:** both masters strobe at the same time after reset → master 0 served first, then master 1 after one IDLE cycle. Sustained requests give grant order 0,1,0,1.
- **Write pass-through:** master 1 writes 0x0000_00F0 while master 0 also requests (`prio`=1) → peripheral sees `write`=1 with data 0xF0 first; master 0 stalls until `m1_response`.
- **Timeout:** `TIMEOUT_CYCLES`=4 with a peripheral that never responds → `m0_response`=`m0_error`=1 exactly 4 BUSY cycles after grant, `read` forced low that cycle, `prio` becomes 1.
- **Reset mid-transfer:** `rst_n` low during a BUSY state with a 3-wait peripheral → all outputs 0 immediately, no response pulse; a fresh request after release is served with master 0 priority.
- **Protocol violation:** master 0 drops its strobe in BUSY before `response` → return to IDLE, no `m0_response`, `prio` unchanged.
